irq_ctrl: RTL and testbench



---
 rtl/irq_ctrl_pkg.sv | 30 +++
 rtl/irq_ctrl_if.sv | 44 ++++
 rtl/irq_ctrl_arb.sv | 65 ++++++
 rtl/irq_ctrl.sv | 146 ++++++++++++++
 tb/tb_irq_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: shared types and constants for the interrupt sequencer.
//   - irq_state_e : sequencer states (IDLE, ENTER, VECTOR, HANDLER, RETURN)
//   - IRQ_ID_W    : width of an interrupt ID
//   - HBIT_ADDR   : top bit of a core address (addresses are HBIT_ADDR+1 wide)
//   - SR_IDX_ILR  : SR slot that receives the interrupt link (return PC)
//   - vec_addr()  : handler vector computation, modulo 2^ADDR_W
package irq_ctrl_pkg;

  localparam int unsigned IRQ_ID_W  = 4;
  localparam int unsigned HBIT_ADDR = 47;
  localparam int unsigned ADDR_W    = HBIT_ADDR + 1;

  localparam logic [4:0] SR_IDX_ILR = 5'd6;

  typedef enum logic [2:0] {
    IRQ_ST_IDLE,
    IRQ_ST_ENTER,
    IRQ_ST_VECTOR,
    IRQ_ST_HANDLER,
    IRQ_ST_RETURN
  } irq_state_e;

  // Base low bits are deliberately not cleared; the sum simply wraps.
  function automatic logic [ADDR_W-1:0] vec_addr(input logic [ADDR_W-1:0]   base,
                                                 input logic [IRQ_ID_W-1:0] id,
                                                 input int unsigned         shift);
    return base + (ADDR_W'(id) << shift);
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: core-side bundle of the interrupt sequencer.
//   iw_* : requests, mask/base writes and EX-stage status (core -> irq_ctrl)
//   ow_* : flush/redirect/link-register/ack/status   (irq_ctrl -> core)
// Modports: master = core side, slave = irq_ctrl.
interface irq_ctrl_if
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 8
);

  logic [NUM_IRQ-1:0]  iw_irq;
  logic                iw_mask_we;
  logic [NUM_IRQ-1:0]  iw_mask_val;
  logic                iw_base_we;
  logic [ADDR_W-1:0]   iw_base_val;
  logic [ADDR_W-1:0]   iw_pc;
  logic                iw_ex_valid;
  logic                iw_stall;
  logic                iw_reti;

  logic                ow_flush;
  logic                ow_redirect;
  logic [ADDR_W-1:0]   ow_redirect_pc;
  logic                ow_lr_we;
  logic [ADDR_W-1:0]   ow_lr;
  logic [NUM_IRQ-1:0]  ow_irq_ack;
  logic                ow_in_handler;
  logic [IRQ_ID_W-1:0] ow_active_id;

  modport master (
    output iw_irq, iw_mask_we, iw_mask_val, iw_base_we, iw_base_val,
           iw_pc, iw_ex_valid, iw_stall, iw_reti,
    input  ow_flush, ow_redirect, ow_redirect_pc, ow_lr_we, ow_lr,
           ow_irq_ack, ow_in_handler, ow_active_id
  );

  modport slave (
    input  iw_irq, iw_mask_we, iw_mask_val, iw_base_we, iw_base_val,
           iw_pc, iw_ex_valid, iw_stall, iw_reti,
    output ow_flush, ow_redirect, ow_redirect_pc, ow_lr_we, ow_lr,
           ow_irq_ack, ow_in_handler, ow_active_id
  );

endinterface

// File: rtl/irq_ctrl_arb.sv
// irq_ctrl_arb (irq_arb): picks one pending request.
//   clk, rst_n : clock, synchronous active-low reset (pointer only)
//   pend       : masked pending requests
//   grant      : strobe, the current pick was accepted
//   id, valid  : picked index and "something is pending"
// IRQ_RR_EN defined  : round-robin from a pointer that moves past each grant.
// IRQ_RR_EN undefined: fixed priority, lowest index wins, no state.
module irq_ctrl_arb
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_IRQ-1:0]  pend,
  input  logic                grant,
  output logic [IRQ_ID_W-1:0] id,
  output logic                valid
);

`ifdef IRQ_RR_EN
  logic [IRQ_ID_W-1:0] ptr_q, ptr_d;

  always_comb begin
    int unsigned idx;
    idx   = 0;
    id    = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      idx = (32'(ptr_q) + i) % NUM_IRQ;
      if (!valid && pend[idx]) begin
        valid = 1'b1;
        id    = IRQ_ID_W'(idx);
      end
    end
  end

  always_comb begin
    int unsigned nxt;
    nxt   = 32'(id) + 1;
    ptr_d = ptr_q;
    if (grant) ptr_d = (nxt >= NUM_IRQ) ? '0 : IRQ_ID_W'(nxt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  logic arb_unused;
  assign arb_unused = ^{clk, rst_n, grant};

  always_comb begin
    id    = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (!valid && pend[i]) begin
        valid = 1'b1;
        id    = IRQ_ID_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt entry/exit sequencer beside the EX stage.
//   iw_clk, iw_rst_n : clock, synchronous active-low reset
//   bus (slave)      : requests, mask/base writes, EX status in;
//                      flush, redirect, link-register write, ack, status out
// Sequence: IDLE -> ENTER (flush + ILR write) -> VECTOR (redirect + ack)
//           -> HANDLER -> RETURN (flush + redirect to saved PC) -> IDLE.
// Handlers do not nest. Define IRQ_RR_EN for round-robin arbitration.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IRQ   = 8,
  parameter int unsigned VEC_SHIFT = 4
) (
  input logic         iw_clk,
  input logic         iw_rst_n,
  irq_ctrl_if.slave   bus
);

  irq_state_e          state_q, state_d;
  logic [NUM_IRQ-1:0]  mask_q, mask_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   ret_pc_q, ret_pc_d;
  logic [ADDR_W-1:0]   vec_q, vec_d;
  logic [IRQ_ID_W-1:0] id_q, id_d;

  logic                flush_q, flush_d;
  logic                redirect_q, redirect_d;
  logic [ADDR_W-1:0]   redirect_pc_q, redirect_pc_d;
  logic                lr_we_q, lr_we_d;
  logic [ADDR_W-1:0]   lr_q, lr_d;
  logic [NUM_IRQ-1:0]  ack_q, ack_d;
  logic                in_handler_q, in_handler_d;

  logic [NUM_IRQ-1:0]  pend;
  logic [IRQ_ID_W-1:0] pick_id;
  logic                pick_valid;
  logic                grant;

  assign pend  = bus.iw_irq & mask_q;
  assign grant = (state_q == IRQ_ST_IDLE) && pick_valid && bus.iw_ex_valid && !bus.iw_stall;

  irq_ctrl_arb #(.NUM_IRQ(NUM_IRQ)) u_arb (
    .clk   (iw_clk),
    .rst_n (iw_rst_n),
    .pend  (pend),
    .grant (grant),
    .id    (pick_id),
    .valid (pick_valid)
  );

  // Outputs are decoded from the next state so they appear registered in
  // the same cycle the state is entered.
  always_comb begin
    state_d  = state_q;
    mask_d   = bus.iw_mask_we ? bus.iw_mask_val : mask_q;
    base_d   = bus.iw_base_we ? bus.iw_base_val : base_q;
    ret_pc_d = ret_pc_q;
    vec_d    = vec_q;
    id_d     = id_q;

    unique case (state_q)
      IRQ_ST_IDLE: if (grant) begin
        state_d  = IRQ_ST_ENTER;
        id_d     = pick_id;
        ret_pc_d = bus.iw_pc;
        vec_d    = vec_addr(base_q, pick_id, VEC_SHIFT);
      end
      IRQ_ST_ENTER:   if (!bus.iw_stall) state_d = IRQ_ST_VECTOR;
      IRQ_ST_VECTOR:  if (!bus.iw_stall) state_d = IRQ_ST_HANDLER;
      IRQ_ST_HANDLER: if (bus.iw_reti && bus.iw_ex_valid && !bus.iw_stall) state_d = IRQ_ST_RETURN;
      IRQ_ST_RETURN:  if (!bus.iw_stall) state_d = IRQ_ST_IDLE;
      default:        state_d = IRQ_ST_IDLE;
    endcase

    flush_d       = 1'b0;
    redirect_d    = 1'b0;
    redirect_pc_d = '0;
    lr_we_d       = 1'b0;
    lr_d          = '0;
    ack_d         = '0;
    in_handler_d  = 1'b0;

    unique case (state_d)
      IRQ_ST_ENTER: begin
        flush_d = 1'b1;
        lr_we_d = 1'b1;
        lr_d    = ret_pc_d;
      end
      IRQ_ST_VECTOR: begin
        redirect_d    = 1'b1;
        redirect_pc_d = vec_d;
        ack_d         = NUM_IRQ'(1) << id_d;
      end
      IRQ_ST_HANDLER: in_handler_d = 1'b1;
      IRQ_ST_RETURN: begin
        flush_d       = 1'b1;
        redirect_d    = 1'b1;
        redirect_pc_d = ret_pc_d;
        in_handler_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iw_clk) begin
    if (!iw_rst_n) begin
      state_q       <= IRQ_ST_IDLE;
      mask_q        <= '0;
      base_q        <= '0;
      ret_pc_q      <= '0;
      vec_q         <= '0;
      id_q          <= '0;
      flush_q       <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      lr_we_q       <= 1'b0;
      lr_q          <= '0;
      ack_q         <= '0;
      in_handler_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      base_q        <= base_d;
      ret_pc_q      <= ret_pc_d;
      vec_q         <= vec_d;
      id_q          <= id_d;
      flush_q       <= flush_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      lr_we_q       <= lr_we_d;
      lr_q          <= lr_d;
      ack_q         <= ack_d;
      in_handler_q  <= in_handler_d;
    end
  end

  assign bus.ow_flush       = flush_q;
  assign bus.ow_redirect    = redirect_q;
  assign bus.ow_redirect_pc = redirect_pc_q;
  assign bus.ow_lr_we       = lr_we_q;
  assign bus.ow_lr          = lr_q;
  assign bus.ow_irq_ack     = ack_q;
  assign bus.ow_in_handler  = in_handler_q;
  assign bus.ow_active_id   = id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: table-driven bench for irq_ctrl (NUM_IRQ = 8, VEC_SHIFT = 4).
// Each row holds one cycle of inputs and the outputs expected after that
// cycle's clock edge. Works with and without IRQ_RR_EN.
module tb_irq_ctrl;

  typedef struct packed {
    logic        flush;
    logic        redir;
    logic [47:0] rpc;
    logic        lr_we;
    logic [47:0] lr;
    logic [7:0]  ack;
    logic        inh;
    logic [3:0]  aid;
  } exp_t;

  typedef struct {
    logic        rst_n;
    logic [7:0]  irq;
    logic        exv;
    logic        stall;
    logic        reti;
    logic [47:0] pc;
    logic        mwe;
    logic [7:0]  mval;
    logic        bwe;
    logic [47:0] bval;
    exp_t        exp;
  } vec_t;

  localparam logic [47:0] B0 = 48'h0123_4567_8000;

`ifdef IRQ_RR_EN
  localparam logic [3:0]  RR_ID  = 4'd3;
  localparam logic [47:0] RR_VEC = 48'h30;
  localparam logic [7:0]  RR_ACK = 8'h08;
`else
  localparam logic [3:0]  RR_ID  = 4'd0;
  localparam logic [47:0] RR_VEC = 48'h0;
  localparam logic [7:0]  RR_ACK = 8'h01;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  irq_ctrl_if #(.NUM_IRQ(8)) bus ();

  irq_ctrl #(.NUM_IRQ(8), .VEC_SHIFT(4)) dut (
    .iw_clk   (clk),
    .iw_rst_n (rst_n),
    .bus      (bus.slave)
  );

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   rows_done = 0;

  function automatic exp_t e_idle(input logic [3:0] aid);
    exp_t e = '0;
    e.aid = aid;
    return e;
  endfunction

  function automatic exp_t e_enter(input logic [47:0] lr, input logic [3:0] aid);
    exp_t e = '0;
    e.flush = 1'b1; e.lr_we = 1'b1; e.lr = lr; e.aid = aid;
    return e;
  endfunction

  function automatic exp_t e_vec(input logic [47:0] rpc, input logic [7:0] ack, input logic [3:0] aid);
    exp_t e = '0;
    e.redir = 1'b1; e.rpc = rpc; e.ack = ack; e.aid = aid;
    return e;
  endfunction

  function automatic exp_t e_hnd(input logic [3:0] aid);
    exp_t e = '0;
    e.inh = 1'b1; e.aid = aid;
    return e;
  endfunction

  function automatic exp_t e_ret(input logic [47:0] rpc, input logic [3:0] aid);
    exp_t e = '0;
    e.flush = 1'b1; e.redir = 1'b1; e.rpc = rpc; e.inh = 1'b1; e.aid = aid;
    return e;
  endfunction

  task automatic add(input logic r, input logic [7:0] irq, input logic exv, input logic stall,
                     input logic reti, input logic [47:0] pc, input logic mwe, input logic [7:0] mval,
                     input logic bwe, input logic [47:0] bval, input exp_t e);
    vec_t v;
    v.rst_n = r; v.irq = irq; v.exv = exv; v.stall = stall; v.reti = reti; v.pc = pc;
    v.mwe = mwe; v.mval = mval; v.bwe = bwe; v.bval = bval; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic addc(input logic r, input logic [7:0] irq, input logic exv, input logic stall,
                      input logic reti, input logic [47:0] pc, input exp_t e);
    add(r, irq, exv, stall, reti, pc, 1'b0, 8'h00, 1'b0, 48'h0, e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    #1;
    if (rst_n === 1'b1) begin
      checks++;
      if ((bus.ow_irq_ack & (bus.ow_irq_ack - 8'd1)) !== 8'h00) begin
        errors++;
        $display("FAIL monitor: ack not one-hot: %h", bus.ow_irq_ack);
      end
      checks++;
      if ((bus.ow_irq_ack !== 8'h00) && (bus.ow_redirect !== 1'b1)) begin
        errors++;
        $display("FAIL monitor: ack %h without redirect", bus.ow_irq_ack);
      end
    end
  end

  initial begin
    exp_t act;
    exp_t want;

    // Reset, then a masked request must stay invisible.
    addc(0, 8'h00, 0, 0, 0, 48'h0, e_idle(0));
    addc(0, 8'h00, 0, 0, 0, 48'h0, e_idle(0));
    for (int i = 0; i < 10; i++) addc(1, 8'h08, 1, 0, 0, 48'h100, e_idle(0));
    add(1, 8'h00, 1, 0, 0, 48'h100, 1, 8'hFF, 1, B0, e_idle(0));

    // Entry on id 3, handler ignores new requests, stalled RETI waits.
    addc(1, 8'h28, 1, 0, 0, 48'h100, e_enter(48'h100, 3));
    addc(1, 8'h28, 1, 0, 0, 48'h104, e_vec(B0 + 48'h30, 8'h08, 3));
    addc(1, 8'h29, 1, 0, 0, 48'h104, e_hnd(3));
    addc(1, 8'h29, 1, 0, 0, 48'h108, e_hnd(3));
    addc(1, 8'h29, 1, 1, 1, 48'h10C, e_hnd(3));
    addc(1, 8'h29, 1, 0, 1, 48'h10C, e_ret(48'h100, 3));
    addc(1, 8'h20, 1, 0, 0, 48'h110, e_idle(3));

    // Immediate re-entry on id 5; stalls hold VECTOR and RETURN.
    addc(1, 8'h20, 1, 0, 0, 48'h200, e_enter(48'h200, 5));
    addc(1, 8'h20, 1, 0, 0, 48'h204, e_vec(B0 + 48'h50, 8'h20, 5));
    for (int i = 0; i < 3; i++) addc(1, 8'h00, 1, 1, 0, 48'h204, e_vec(B0 + 48'h50, 8'h20, 5));
    addc(1, 8'h00, 1, 0, 0, 48'h204, e_hnd(5));
    addc(1, 8'h00, 1, 0, 1, 48'h208, e_ret(48'h200, 5));
    addc(1, 8'h00, 1, 1, 0, 48'h208, e_ret(48'h200, 5));
    addc(1, 8'h00, 1, 0, 0, 48'h208, e_idle(5));
    addc(1, 8'h00, 1, 0, 1, 48'h20C, e_idle(5));

    // Stall blocks the decision; base write during ENTER affects next entry only.
    for (int i = 0; i < 3; i++) addc(1, 8'h02, 1, 1, 0, 48'h300, e_idle(5));
    addc(1, 8'h02, 1, 0, 0, 48'h300, e_enter(48'h300, 1));
    add(1, 8'h02, 1, 0, 0, 48'h300, 0, 8'h00, 1, 48'hFFFF_FFFF_FFF0, e_vec(B0 + 48'h10, 8'h02, 1));
    addc(1, 8'h00, 1, 0, 0, 48'h304, e_hnd(1));
    addc(1, 8'h00, 1, 0, 1, 48'h304, e_ret(48'h300, 1));
    addc(1, 8'h00, 1, 0, 0, 48'h308, e_idle(1));

    // ex_valid low blocks entry; vector wraps modulo 2^48.
    addc(1, 8'h04, 0, 0, 0, 48'h400, e_idle(1));
    addc(1, 8'h04, 1, 0, 0, 48'h400, e_enter(48'h400, 2));
    addc(1, 8'h04, 1, 0, 0, 48'h404, e_vec(48'h10, 8'h04, 2));
    addc(1, 8'h00, 1, 0, 0, 48'h404, e_hnd(2));
    addc(1, 8'h00, 1, 0, 1, 48'h404, e_ret(48'h400, 2));
    addc(1, 8'h00, 1, 0, 0, 48'h408, e_idle(2));

    // Mask write is effective the next cycle; reset in ENTER aborts with no ack.
    add(1, 8'h00, 1, 0, 0, 48'h500, 1, 8'hFB, 0, 48'h0, e_idle(2));
    addc(1, 8'h04, 1, 0, 0, 48'h500, e_idle(2));
    add(1, 8'h04, 1, 0, 0, 48'h500, 1, 8'hFF, 0, 48'h0, e_idle(2));
    addc(1, 8'h04, 1, 0, 0, 48'h500, e_enter(48'h500, 2));
    addc(0, 8'h04, 1, 0, 0, 48'h500, e_idle(0));
    addc(1, 8'h04, 1, 0, 0, 48'h500, e_idle(0));
    addc(1, 8'h04, 1, 0, 0, 48'h500, e_idle(0));

    // Two rounds with 0x09 held: arbitration policy decides the second id.
    add(1, 8'h00, 1, 0, 0, 48'h600, 1, 8'hFF, 0, 48'h0, e_idle(0));
    addc(1, 8'h09, 1, 0, 0, 48'h600, e_enter(48'h600, 0));
    addc(1, 8'h09, 1, 0, 0, 48'h604, e_vec(48'h0, 8'h01, 0));
    addc(1, 8'h09, 1, 0, 0, 48'h604, e_hnd(0));
    addc(1, 8'h09, 1, 0, 1, 48'h604, e_ret(48'h600, 0));
    addc(1, 8'h09, 1, 0, 0, 48'h608, e_idle(0));
    addc(1, 8'h09, 1, 0, 0, 48'h700, e_enter(48'h700, RR_ID));
    addc(1, 8'h09, 1, 0, 0, 48'h704, e_vec(RR_VEC, RR_ACK, RR_ID));
    addc(1, 8'h09, 1, 0, 0, 48'h704, e_hnd(RR_ID));
    addc(1, 8'h09, 1, 0, 1, 48'h704, e_ret(48'h700, RR_ID));
    addc(1, 8'h00, 1, 0, 0, 48'h708, e_idle(RR_ID));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst_n           = tbl[i].rst_n;
      bus.iw_irq      = tbl[i].irq;
      bus.iw_ex_valid = tbl[i].exv;
      bus.iw_stall    = tbl[i].stall;
      bus.iw_reti     = tbl[i].reti;
      bus.iw_pc       = tbl[i].pc;
      bus.iw_mask_we  = tbl[i].mwe;
      bus.iw_mask_val = tbl[i].mval;
      bus.iw_base_we  = tbl[i].bwe;
      bus.iw_base_val = tbl[i].bval;
      sb.push_back(tbl[i].exp);
      @(posedge clk);
      #1;
      want       = sb.pop_front();
      act.flush  = bus.ow_flush;
      act.redir  = bus.ow_redirect;
      act.rpc    = bus.ow_redirect_pc;
      act.lr_we  = bus.ow_lr_we;
      act.lr     = bus.ow_lr;
      act.ack    = bus.ow_irq_ack;
      act.inh    = bus.ow_in_handler;
      act.aid    = bus.ow_active_id;
      checks++;
      rows_done++;
      if (act !== want) begin
        errors++;
        $display("FAIL row%0d: got flush=%b redir=%b rpc=%h lr_we=%b lr=%h ack=%h inh=%b aid=%0d, want flush=%b redir=%b rpc=%h lr_we=%b lr=%h ack=%h inh=%b aid=%0d",
                 i, act.flush, act.redir, act.rpc, act.lr_we, act.lr, act.ack, act.inh, act.aid,
                 want.flush, want.redir, want.rpc, want.lr_we, want.lr, want.ack, want.inh, want.aid);
      end
    end

    checks++;
    if (rows_done != tbl.size()) begin
      errors++;
      $display("FAIL: only %0d of %0d rows compared", rows_done, tbl.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
